// File: rtl/fwd_pkg.sv
// Shared types and helpers for the operand-forwarding select block.
// The entry flags live here; the data field is added where DataWidth is known.
package fwd_pkg;

  localparam int unsigned CntWidth = 32;

  typedef struct packed {
    logic valid;
    logic ready;
  } fwd_flags_t;

  // Saturating increment used by the optional statistics counters.
  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] value,
                                                  input logic                 en);
    logic [CntWidth-1:0] result;
    if (en && (value != {CntWidth{1'b1}})) begin
      result = value + {{(CntWidth-1){1'b0}}, 1'b1};
    end else begin
      result = value;
    end
    return result;
  endfunction

endpackage

// File: rtl/fwd_priority_select.sv
// Combinational youngest-match picker: one-hot select of the lowest matching
// stage, plus hit and "selected producer not ready" flags.
module fwd_priority_select #(
  parameter int Depth = 1
) (
  input  logic [Depth-1:0] match,
  input  logic [Depth-1:0] ready,
  output logic [Depth-1:0] sel,
  output logic             hit,
  output logic             not_ready
);

  logic found_s;

  // Walk from the youngest stage; the first match masks all older ones.
  always_comb begin
    sel     = '0;
    found_s = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      sel[i]  = match[i] & ~found_s;
      found_s = found_s | match[i];
    end
    hit       = |match;
    not_ready = |(sel & ~ready);
  end

endmodule

// File: rtl/fwd_operand_select.sv
// Operand forwarding select with a shift buffer of in-flight results and a
// late-result fill path. Optional counters under FWD_OPERAND_SELECT_STATS_EN.
module fwd_operand_select
  import fwd_pkg::*;
#(
  parameter int ForwardDepth = 1,
  parameter int DataWidth    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_en,
  input  logic [ForwardDepth-1:0] FwdEnable,
  input  logic [DataWidth-1:0]    RegFileData,
  input  logic                    WrValid,
  input  logic                    WrReady,
  input  logic [DataWidth-1:0]    WrData,
  input  logic                    LateValid,
  input  logic [DataWidth-1:0]    LateData,
  output logic [DataWidth-1:0]    Operand,
  output logic                    FwdHit,
  output logic                    Stall
`ifdef FWD_OPERAND_SELECT_STATS_EN
  ,
  output logic [CntWidth-1:0]     FwdCount,
  output logic [CntWidth-1:0]     StallCount
`endif
);

  typedef struct packed {
    fwd_flags_t             flags;
    logic [DataWidth-1:0]   data;
  } entry_t;

  entry_t                  entry_r  [ForwardDepth];
  entry_t                  filled_s [ForwardDepth];
  logic [ForwardDepth-1:0] match_s;
  logic [ForwardDepth-1:0] ready_s;
  logic [ForwardDepth-1:0] pend_s;
  logic [ForwardDepth-1:0] late_tgt_s;
  logic [ForwardDepth-1:0] sel_s;
  logic                    hit_s;
  logic                    not_ready_s;
  logic                    bypass_s;
  logic                    late_found_s;
  logic [DataWidth-1:0]    sel_data_s;

  // Per-stage match, readiness and oldest-pending late target.
  always_comb begin
    late_tgt_s   = '0;
    late_found_s = 1'b0;
    for (int i = 0; i < ForwardDepth; i++) begin
      match_s[i] = FwdEnable[i] & entry_r[i].flags.valid;
      ready_s[i] = entry_r[i].flags.ready;
      pend_s[i]  = entry_r[i].flags.valid & ~entry_r[i].flags.ready;
    end
    for (int i = ForwardDepth - 1; i >= 0; i--) begin
      late_tgt_s[i] = pend_s[i] & ~late_found_s;
      late_found_s  = late_found_s | pend_s[i];
    end
  end

  fwd_priority_select #(
    .Depth (ForwardDepth)
  ) u_priority_select (
    .match     (match_s),
    .ready     (ready_s),
    .sel       (sel_s),
    .hit       (hit_s),
    .not_ready (not_ready_s)
  );

  // One-hot data mux over the buffer.
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < ForwardDepth; i++) begin
      sel_data_s = sel_data_s | (entry_r[i].data & {DataWidth{sel_s[i]}});
    end
  end

  // Late bypass only helps when the selected stage is the oldest pending one.
  always_comb begin
    bypass_s = not_ready_s & LateValid & (|(late_tgt_s & sel_s));
    Stall    = not_ready_s & ~bypass_s;
    FwdHit   = hit_s & ~Stall;
    if (hit_s && !not_ready_s) begin
      Operand = sel_data_s;
    end else if (bypass_s) begin
      Operand = LateData;
    end else begin
      Operand = RegFileData;
    end
  end

  // Current entries with any late completion applied at the target stage.
  always_comb begin
    for (int i = 0; i < ForwardDepth; i++) begin
      filled_s[i]             = entry_r[i];
      filled_s[i].flags.ready = entry_r[i].flags.ready | (LateValid & late_tgt_s[i]);
      filled_s[i].data        = (LateValid && late_tgt_s[i]) ? LateData : entry_r[i].data;
    end
  end

  // Shift buffer: advance on clk_en (last stage drops out), otherwise fill in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ForwardDepth; i++) begin
        entry_r[i] <= '0;
      end
    end else if (clk_en) begin
      entry_r[0] <= Stall ? entry_t'('0) : entry_t'({WrValid, WrReady, WrData});
      for (int i = 1; i < ForwardDepth; i++) begin
        entry_r[i] <= filled_s[i-1];
      end
    end else begin
      for (int i = 0; i < ForwardDepth; i++) begin
        entry_r[i] <= filled_s[i];
      end
    end
  end

`ifdef FWD_OPERAND_SELECT_STATS_EN
  // Saturating event counters, advancing only with the pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      FwdCount   <= '0;
      StallCount <= '0;
    end else if (clk_en) begin
      FwdCount   <= sat_inc(FwdCount, FwdHit);
      StallCount <= sat_inc(StallCount, Stall);
    end
  end
`endif

endmodule

// File: tb/tb_fwd_operand_select.sv
// Directed self-checking bench for fwd_operand_select (ForwardDepth=3, DataWidth=8).
module tb_fwd_operand_select;

  logic       clk;
  logic       rst_n;
  logic       clk_en;
  logic [2:0] FwdEnable;
  logic [7:0] RegFileData;
  logic       WrValid;
  logic       WrReady;
  logic [7:0] WrData;
  logic       LateValid;
  logic [7:0] LateData;
  logic [7:0] Operand;
  logic       FwdHit;
  logic       Stall;
`ifdef FWD_OPERAND_SELECT_STATS_EN
  logic [31:0] FwdCount;
  logic [31:0] StallCount;
`endif

  int checks = 0;
  int errors = 0;

  fwd_operand_select #(
    .ForwardDepth (3),
    .DataWidth    (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_en      (clk_en),
    .FwdEnable   (FwdEnable),
    .RegFileData (RegFileData),
    .WrValid     (WrValid),
    .WrReady     (WrReady),
    .WrData      (WrData),
    .LateValid   (LateValid),
    .LateData    (LateData),
    .Operand     (Operand),
    .FwdHit      (FwdHit),
    .Stall       (Stall)
`ifdef FWD_OPERAND_SELECT_STATS_EN
    ,
    .FwdCount    (FwdCount),
    .StallCount  (StallCount)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Set FwdEnable, let the combinational outputs settle, compare all three.
  task automatic check_out(input string tag, input logic [2:0] fe,
                           input logic [7:0] op, input logic hit, input logic stall);
    FwdEnable = fe;
    #1;
    check_value({tag, "_op"}, {24'd0, Operand}, {24'd0, op});
    check_value({tag, "_hit"}, {31'd0, FwdHit}, {31'd0, hit});
    check_value({tag, "_stall"}, {31'd0, Stall}, {31'd0, stall});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input logic v, input logic r, input logic [7:0] d);
    WrValid = v;
    WrReady = r;
    WrData  = d;
  endtask

  initial begin
    rst_n       = 1'b0;
    clk_en      = 1'b1;
    FwdEnable   = 3'b000;
    RegFileData = 8'h33;
    LateValid   = 1'b0;
    LateData    = 8'h00;
    drive_wr(1'b0, 1'b0, 8'h00);

    // Reset state and all-invalid buffer
    #2;
    check_out("rst", 3'b111, 8'h33, 1'b0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    check_out("allinv", 3'b111, 8'h33, 1'b0, 1'b0);
`ifdef FWD_OPERAND_SELECT_STATS_EN
    check_value("rst_fwdcnt", FwdCount, 32'd0);
    check_value("rst_stallcnt", StallCount, 32'd0);
`endif

    // Ready result forwarded from stage 1
    FwdEnable = 3'b000;
    drive_wr(1'b1, 1'b1, 8'h11);
    step();
    drive_wr(1'b0, 1'b0, 8'h00);
    step();
    check_out("fwd_s1", 3'b010, 8'h11, 1'b1, 1'b0);
    check_out("bubble_s0", 3'b001, 8'h33, 1'b0, 1'b0);

    // Youngest producer wins: s0=AA, s2=BB
    FwdEnable = 3'b000;
    drive_wr(1'b1, 1'b1, 8'hBB);
    step();
    drive_wr(1'b0, 1'b0, 8'h00);
    step();
    drive_wr(1'b1, 1'b1, 8'hAA);
    step();
    drive_wr(1'b0, 1'b0, 8'h00);
    check_out("young_wins", 3'b101, 8'hAA, 1'b1, 1'b0);
    check_out("old_only", 3'b100, 8'hBB, 1'b1, 1'b0);
    check_out("inv_s1", 3'b010, 8'h33, 1'b0, 1'b0);

    // Late producer at stage 0 stalls; a bubble enters
    FwdEnable = 3'b000;
    drive_wr(1'b1, 1'b0, 8'h00);
    step();
    drive_wr(1'b1, 1'b1, 8'h77);
    check_out("late_stall", 3'b001, 8'h33, 1'b0, 1'b1);
    check_out("late_stall_mask", 3'b011, 8'h33, 1'b0, 1'b1);
    step();
    drive_wr(1'b0, 1'b0, 8'h00);
    check_out("bubble_in", 3'b001, 8'h33, 1'b0, 1'b0);
    check_out("no_older", 3'b110, 8'h33, 1'b0, 1'b1);
    check_out("older_ok", 3'b100, 8'hAA, 1'b1, 1'b0);
    LateValid = 1'b1;
    LateData  = 8'h5C;
    check_out("bypass", 3'b010, 8'h5C, 1'b1, 1'b0);
    step();
    LateValid = 1'b0;
    check_out("fill_shift", 3'b100, 8'h5C, 1'b1, 1'b0);
    check_out("fill_noleak", 3'b010, 8'h33, 1'b0, 1'b0);

    // Late fill whose target leaves the last stage on the same edge
    FwdEnable = 3'b000;
    drive_wr(1'b1, 1'b0, 8'h00);
    step();
    drive_wr(1'b0, 1'b0, 8'h00);
    step();
    step();
    check_out("late_s2", 3'b100, 8'h33, 1'b0, 1'b1);
    LateValid = 1'b1;
    LateData  = 8'h42;
    check_out("bypass_s2", 3'b100, 8'h42, 1'b1, 1'b0);
    step();
    LateValid = 1'b0;
    check_out("shift_out", 3'b111, 8'h33, 1'b0, 1'b0);
    LateValid = 1'b1;
    LateData  = 8'h99;
    step();
    LateValid = 1'b0;
    check_out("late_nopend", 3'b111, 8'h33, 1'b0, 1'b0);

    // Fill in place and hold with clk_en=0
    FwdEnable = 3'b000;
    drive_wr(1'b1, 1'b0, 8'h00);
    step();
    drive_wr(1'b0, 1'b0, 8'h00);
    clk_en    = 1'b0;
    LateValid = 1'b1;
    LateData  = 8'h3C;
    step();
    LateValid = 1'b0;
    check_out("fill_inplace", 3'b001, 8'h3C, 1'b1, 1'b0);
    drive_wr(1'b1, 1'b1, 8'h55);
    FwdEnable = 3'b000;
    step();
    check_out("hold_en0", 3'b001, 8'h3C, 1'b1, 1'b0);
    clk_en = 1'b1;

    // Asynchronous reset in the middle of a stall
    FwdEnable = 3'b000;
    drive_wr(1'b1, 1'b0, 8'h00);
    step();
    drive_wr(1'b0, 1'b0, 8'h00);
    check_out("pre_rst_stall", 3'b001, 8'h33, 1'b0, 1'b1);
    rst_n = 1'b0;
    check_out("rst_async", 3'b001, 8'h33, 1'b0, 1'b0);
    check_out("rst_cleared", 3'b010, 8'h33, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    step();

    // Counter run: 5 forwarding cycles, 2 stall cycles, plus clk_en=0 idles
    FwdEnable = 3'b000;
    drive_wr(1'b1, 1'b1, 8'h10);
    step();
    FwdEnable = 3'b001;
    for (int i = 0; i < 5; i++) begin
      step();
    end
    check_out("cnt_fwd", 3'b001, 8'h10, 1'b1, 1'b0);
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
    end
    clk_en    = 1'b1;
    FwdEnable = 3'b000;
    drive_wr(1'b1, 1'b0, 8'h00);
    step();
    drive_wr(1'b0, 1'b0, 8'h00);
    FwdEnable = 3'b001;
    step();
    FwdEnable = 3'b010;
    step();
    clk_en = 1'b0;
    check_out("cnt_stall", 3'b100, 8'h33, 1'b0, 1'b1);
    step();
    step();
    FwdEnable = 3'b000;
    clk_en    = 1'b1;
`ifdef FWD_OPERAND_SELECT_STATS_EN
    check_value("fwd_count", FwdCount, 32'd5);
    check_value("stall_count", StallCount, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_operand_select.md
FWD_OPERAND_SELECT -- requirements
Module: fwd_operand_select

Interface
REQ-001 Parameter ForwardDepth, default 1, number of in-flight result stages tracked; matches the upstream forward-enable vector width.
REQ-002 Parameter DataWidth, default 8, operand/result data width in bits.
REQ-003 One clock; reset is asynchronous and active-low. Port clk, input, 1, rising-edge clock.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port clk_en, input, 1, pipeline advance; when low no state changes.
REQ-006 Port FwdEnable, input, ForwardDepth, per-stage register-address match from the upstream hazard table; bit i refers to stage i, and stage 0 is youngest.
REQ-007 Port RegFileData, input, DataWidth, operand read from the register file.
REQ-008 Port WrValid, input, 1, the instruction entering stage 0 writes a register.
REQ-009 Port WrReady, input, 1, the result is available at entry (0 = late result, e.g. a load).
REQ-010 Port WrData, input, DataWidth, result value when WrReady=1.
REQ-011 Port LateValid / LateData, input, 1 / DataWidth, completion of the oldest pending late result.
REQ-012 Port Operand, output, DataWidth, selected operand value.
REQ-013 Port FwdHit, output, 1, Operand comes from a forwarded stage.
REQ-014 Port Stall, output, 1, the selected producer is not ready and the consumer must wait.

Function
REQ-015 The block SHALL keep a ForwardDepth-deep shift buffer of entries, each holding valid, ready and data.
REQ-016 On clk && clk_en, entry i SHALL move to i+1, and the entry in the last stage SHALL be discarded, whether or not it is ready.
REQ-017 When Stall=0, stage 0 SHALL load {WrValid, WrReady, WrData}; when Stall=1, stage 0 SHALL load a bubble with valid=0.
REQ-018 Effective match m[i] = FwdEnable[i] AND valid[i]; invalid entries SHALL never forward.
REQ-019 Selection SHALL use the lowest i with m[i]=1 (youngest producer wins); if no stage matches, Operand = RegFileData, FwdHit=0 and Stall=0.
REQ-020 If the selected entry has ready=1: Operand = data, FwdHit=1, Stall=0.
REQ-021 If the selected entry has ready=0 and LateValid=1 targets that entry: Operand = LateData, FwdHit=1, Stall=0 (same-cycle bypass).
REQ-022 If the selected entry has ready=0 and no bypass applies: Stall=1, FwdHit=0, Operand = RegFileData. Older matching entries SHALL NOT be used.
REQ-023 The target of LateValid SHALL be the highest-index entry with valid=1 and ready=0. On clk_en the fill SHALL apply to that entry at its post-shift position; with clk_en=0 it SHALL fill in place.
REQ-024 LateValid with no pending entry, or whose target shifts out on the same edge, SHALL be ignored.
REQ-025 Operand, FwdHit and Stall SHALL be combinational from current state and inputs, with zero-cycle latency.

Reset
REQ-026 rst_n low SHALL clear all valid, ready and data bits immediately, regardless of clk_en.
REQ-027 Outputs during and after reset: Stall=0, FwdHit=0, Operand = RegFileData. Reset asserted mid-stall SHALL release Stall asynchronously.

Configuration
REQ-028 With FWD_OPERAND_SELECT_STATS_EN defined, the block SHALL add outputs FwdCount[31:0] and StallCount[31:0]. On clk_en these increment when FwdHit=1 and Stall=1 respectively, saturate at all-ones, and reset to 0.
REQ-029 Without the macro, these ports and counters SHALL be absent and the core behaviour SHALL be identical.

Structure
REQ-030 Shared package fwd_pkg SHALL hold the entry struct typedef (valid, ready, data; parameterised via DataWidth) and the counter width constant.
REQ-031 Sub-module fwd_priority_select SHALL be purely combinational: it takes m[] and ready[] and returns a one-hot selection, hit and not-ready flags.

Verification
REQ-032 ForwardDepth=3. Write 0x11 ready, then idle one cycle, then FwdEnable=3'b010 -> Operand=0x11, FwdHit=1, Stall=0.
REQ-033 Stages 0 and 2 both valid and ready with data 0xAA and 0xBB, FwdEnable=3'b101 -> Operand=0xAA.
REQ-034 Late entry (WrReady=0) at stage 0, FwdEnable=3'b001 -> Stall=1 and a bubble enters on the next clk_en. Then LateValid with LateData=0x5C in the same cycle -> Stall=0, Operand=0x5C.
REQ-035 FwdEnable=3'b111 while all entries are invalid after reset -> Operand=RegFileData, FwdHit=0, Stall=0.
REQ-036 Pending late entry shifted out of the last stage, then LateValid=1 -> no state change. Also drive rst_n low while Stall=1 -> Stall drops without a clock edge.
REQ-037 With FWD_OPERAND_SELECT_STATS_EN, run 5 forwarding cycles and 2 stall cycles -> FwdCount=5, StallCount=2; with clk_en=0 throughout the counts stay unchanged.
